dcache_stall_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and the off-chip data memory.
- Owns the tag, valid and dirty state and the line storage.
- Sequences write-back and refill transactions over a req/ack memory port.
- Drives the MemStall that freezes the PC and the pipeline registers while a miss is serviced.

---
 rtl/dcache_stall_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_dcache_stall_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_stall_controller.sv
// -----------------------------------------------------------------------------
// dcache_stall_controller
//
// Direct-mapped, write-back, write-allocate data cache controller that sits
// between the MEM stage and off-chip data memory. It owns the tag/valid/dirty
// state and the line storage, and it sequences victim write-back and line
// refill over a req/ack memory port. While a miss is being serviced it holds
// stall_o high to freeze the PC and the pipeline registers.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-low reset
//   cpu_req_i    MEM-stage access valid (load or store)
//   cpu_we_i     1 = store, 0 = load
//   cpu_addr_i   word-aligned byte address
//   cpu_data_i   store data
//   cpu_data_o   load data, valid when cpu_req_i=1 and stall_o=0
//   stall_o      MemStall to PC and pipeline registers
//   mem_req_o    memory transaction request (registered)
//   mem_we_o     1 = write-back, 0 = refill read
//   mem_addr_o   line-aligned memory address
//   mem_data_o   victim line for write-back
//   mem_data_i   refill line, valid in the mem_ack_i cycle
//   mem_ack_i    single-cycle completion pulse
// -----------------------------------------------------------------------------
module dcache_stall_controller #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_FILL_DONE
    } state_e;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [2:0]       word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             addr_unused;

    assign word_sel    = cpu_addr_i[4:2];
    assign idx         = cpu_addr_i[5+IDX_W-1:5];
    assign tag         = cpu_addr_i[31:5+IDX_W];
    // Byte offset bits are always zero for word-aligned accesses.
    assign addr_unused = ^cpu_addr_i[1:0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // Line address of the access that missed; the transaction finishes on
    // this address even if the CPU inputs move while stalled.
    logic [TAG_W-1:0]     miss_tag_q;
    logic [IDX_W-1:0]     miss_idx_q;

    logic                 mem_req_q,  mem_req_d;
    logic                 mem_we_q,   mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    // -------------------------------------------------------------------------
    // Lookup
    // -------------------------------------------------------------------------
    logic                 hit;
    logic                 victim_dirty;
    logic [LINE_BITS-1:0] rd_line;
    logic [31:0]          rd_word;
    logic                 miss;
    logic                 store_hit;
    logic                 fill;

    assign rd_line      = data_q[idx];
    assign rd_word      = rd_line[{word_sel, 5'b0} +: 32];
    assign hit          = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign victim_dirty = valid_q[idx] & dirty_q[idx];

    assign miss      = (state_q == S_IDLE) & cpu_req_i & ~hit;
    assign store_hit = (state_q == S_IDLE) & hit & cpu_we_i;
    assign fill      = (state_q == S_REFILL) & mem_ack_i;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req_i && !hit) begin
                    state_d = victim_dirty ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (mem_ack_i) state_d = S_FILL_DONE;
            end
            S_FILL_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (CPU side combinational, memory side next values)
    // -------------------------------------------------------------------------
    always_comb begin
        // Gated by reset so the pipeline is released while rst_i is low even
        // if the MEM stage still presents an access.
        stall_o    = rst_i & ((state_q != S_IDLE) | miss);
        cpu_data_o = ((state_q == S_IDLE) && hit) ? rd_word : 32'b0;

        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    mem_req_d = 1'b1;
                    if (victim_dirty) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = {tag_q[idx], idx, 5'b0};
                        mem_data_d = rd_line;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, 5'b0};
                    end
                end
            end
            S_WRITEBACK: begin
                // Chain straight into the refill without dropping req.
                if (mem_ack_i) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {miss_tag_q, miss_idx_q, 5'b0};
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered memory port and miss capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'b0;
            mem_data_q <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            if (miss) begin
                miss_tag_q <= tag;
                miss_idx_q <= idx;
            end
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

    // -------------------------------------------------------------------------
    // Valid / dirty bits
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Tag and line storage
    // -------------------------------------------------------------------------
    // NOTE: the arrays have no reset; valid_q alone qualifies their contents,
    // which keeps them mappable to plain RAM.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_q[miss_idx_q] <= mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (store_hit) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= cpu_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_stall_controller
//
// Directed bench for dcache_stall_controller. Inputs change 2 time units after
// each rising edge and outputs are compared 1 unit later, away from the edge.
// Memory acks are driven by hand at fixed cycles.
// -----------------------------------------------------------------------------
module tb_dcache_stall_controller;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int checks;
    int errors;

    dcache_stall_controller #(
        .NUM_LINES(16),
        .LINE_BITS(256)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    logic [255:0] line1;

    initial begin
        checks     = 0;
        errors     = 0;
        rst_i      = 1'b0;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_data_i = 32'h0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_stall",    32'(stall_o),      0);
        check("rst_mem_req",  32'(mem_req_o),    0);
        check("rst_mem_we",   32'(mem_we_o),     0);
        check("rst_mem_addr", mem_addr_o,        0);
        check("rst_cpu_data", cpu_data_o,        0);
        check("rst_mem_data", mem_data_o[31:0],  0);

        // Cold load miss to 0x40: stall in the same cycle (cycle 0).
        rst_i      = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0040;
        #1;
        check("miss0_stall",   32'(stall_o),   1);
        check("miss0_req_low", 32'(mem_req_o), 0);

        tick(); // cycle 1: REFILL request visible
        #1;
        check("refill0_req",  32'(mem_req_o), 1);
        check("refill0_we",   32'(mem_we_o),  0);
        check("refill0_addr", mem_addr_o,     32'h0000_0040);

        // Pipeline moves the address to 0x48 mid-miss; the transaction must
        // keep the captured 0x40 line.
        cpu_addr_i = 32'h0000_0048;
        repeat (7) tick(); // cycle 8
        #1;
        check("refill0_hold_req",  32'(mem_req_o), 1);
        check("refill0_hold_addr", mem_addr_o,     32'h0000_0040);
        check("refill0_hold_stall", 32'(stall_o),  1);

        tick(); // cycle 9: ack with refill data
        line1 = mk_line(32'hA000_0000);
        line1[95:64] = 32'hDEAD_BEEF;
        mem_data_i = line1;
        mem_ack_i  = 1'b1;
        #1;
        check("ack0_stall", 32'(stall_o), 1);

        tick(); // cycle 10: FILL_DONE
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        check("filldone0_req",   32'(mem_req_o), 0);
        check("filldone0_stall", 32'(stall_o),   1);

        tick(); // cycle 11: IDLE re-evaluates 0x48 as a hit
        #1;
        check("load48_stall", 32'(stall_o), 0);
        check("load48_data",  cpu_data_o,   32'hDEAD_BEEF);

        tick(); // second load of 0x48 hits with no stall; stray ack ignored
        mem_ack_i = 1'b1;
        #1;
        check("load48b_stall", 32'(stall_o), 0);
        check("load48b_data",  cpu_data_o,   32'hDEAD_BEEF);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("stray_ack_req",   32'(mem_req_o), 0);
        check("stray_ack_stall", 32'(stall_o),   0);

        // Store hit to 0x44, then read it back.
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h0000_0044;
        cpu_data_i = 32'h1234_5678;
        #1;
        check("store44_stall", 32'(stall_o), 0);
        tick();
        cpu_we_i = 1'b0;
        #1;
        check("load44_stall", 32'(stall_o), 0);
        check("load44_data",  cpu_data_o,   32'h1234_5678);
        cpu_addr_i = 32'h0000_0040;
        #1;
        check("load40_data", cpu_data_o, 32'hA000_0000);

        // Conflict miss 0x240 on index 2 with a dirty victim.
        cpu_addr_i = 32'h0000_0240;
        #1;
        check("miss240_stall", 32'(stall_o), 1);
        tick(); // WRITEBACK
        #1;
        check("wb_req",   32'(mem_req_o),       1);
        check("wb_we",    32'(mem_we_o),        1);
        check("wb_addr",  mem_addr_o,           32'h0000_0040);
        check("wb_word1", mem_data_o[63:32],    32'h1234_5678);
        check("wb_word2", mem_data_o[95:64],    32'hDEAD_BEEF);
        repeat (2) tick();
        #1;
        check("wb_hold_addr", mem_addr_o,     32'h0000_0040);
        check("wb_hold_we",   32'(mem_we_o),  1);
        mem_ack_i = 1'b1;
        #1;
        check("wb_ack_stall", 32'(stall_o), 1);
        tick(); // REFILL, request re-issued without a gap
        mem_ack_i = 1'b0;
        #1;
        check("refill240_req",   32'(mem_req_o), 1);
        check("refill240_we",    32'(mem_we_o),  0);
        check("refill240_addr",  mem_addr_o,     32'h0000_0240);
        check("refill240_stall", 32'(stall_o),   1);
        tick();
        mem_data_i = mk_line(32'h1111_0000);
        mem_ack_i  = 1'b1;
        tick(); // FILL_DONE
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        check("filldone240_stall", 32'(stall_o),   1);
        check("filldone240_req",   32'(mem_req_o), 0);
        tick(); // IDLE hit
        #1;
        check("load240_stall", 32'(stall_o), 0);
        check("load240_data",  cpu_data_o,   32'h1111_0000);

        // Store miss to clean/invalid line 0x80 (index 4): write-allocate.
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h0000_0080;
        cpu_data_i = 32'hCAFE_F00D;
        #1;
        check("smiss80_stall", 32'(stall_o), 1);
        tick();
        #1;
        check("smiss80_we",   32'(mem_we_o), 0);
        check("smiss80_addr", mem_addr_o,    32'h0000_0080);
        mem_data_i = mk_line(32'h3333_0000);
        mem_ack_i  = 1'b1;
        tick(); // FILL_DONE
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        #1;
        check("smiss80_filldone_stall", 32'(stall_o), 1);
        tick(); // IDLE: store merges at the next edge
        #1;
        check("smiss80_merge_stall", 32'(stall_o), 0);
        tick();
        cpu_we_i = 1'b0;
        #1;
        check("load80_data", cpu_data_o, 32'hCAFE_F00D);
        cpu_addr_i = 32'h0000_0084;
        #1;
        check("load84_data", cpu_data_o, 32'h3333_0001);

        // Evict 0x80 with 0x280: merged store must appear in the write-back.
        cpu_addr_i = 32'h0000_0280;
        #1;
        check("miss280_stall", 32'(stall_o), 1);
        tick();
        #1;
        check("wb80_we",    32'(mem_we_o),     1);
        check("wb80_addr",  mem_addr_o,        32'h0000_0080);
        check("wb80_word0", mem_data_o[31:0],  32'hCAFE_F00D);
        check("wb80_word1", mem_data_o[63:32], 32'h3333_0001);
        mem_ack_i = 1'b1;
        tick(); // REFILL of 0x280
        mem_ack_i = 1'b0;
        #1;
        check("refill280_req",  32'(mem_req_o), 1);
        check("refill280_addr", mem_addr_o,     32'h0000_0280);

        // Reset during REFILL: immediate return to reset values.
        rst_i = 1'b0;
        #1;
        check("midrst_req",   32'(mem_req_o), 0);
        check("midrst_stall", 32'(stall_o),   0);
        check("midrst_addr",  mem_addr_o,     0);
        tick();
        rst_i      = 1'b1;
        cpu_addr_i = 32'h0000_0080;
        #1;
        check("postrst_miss_stall", 32'(stall_o), 1);
        tick();
        #1;
        check("postrst_req",  32'(mem_req_o), 1);
        check("postrst_we",   32'(mem_we_o),  0);
        check("postrst_addr", mem_addr_o,     32'h0000_0080);
        mem_data_i = mk_line(32'h4444_0000);
        mem_ack_i  = 1'b1;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        tick();
        #1;
        check("postrst_load_stall", 32'(stall_o), 0);
        check("postrst_load_data",  cpu_data_o,   32'h4444_0000);

        cpu_req_i = 1'b0;
        #1;
        check("noreq_stall", 32'(stall_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
